// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the SPI-to-SDRAM command bridge.
// Opcodes, register map and fault word live here so the bench and RTL agree.
package spi_mem_pkg;

    localparam logic [15:0] OP_RD       = 16'hC000;
    localparam logic [15:0] OP_WR       = 16'hC100;
    localparam logic [15:0] OP_REG      = 16'h8000;
    localparam logic [15:0] OP_REG_MASK = 16'hFF00;
    localparam logic [15:0] DEAD_WORD   = 16'hDEAD;

    localparam logic [7:0] REG_ID   = 8'h00;
    localparam logic [7:0] REG_STAT = 8'h01;
    localparam logic [7:0] REG_LAST = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        WDATA,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        REG_ARG
    } state_e;

    function automatic logic is_reg_op(input logic [15:0] w);
        return (w & OP_REG_MASK) == OP_REG;
    endfunction

endpackage

// File: rtl/spi_mem_bridge_if.sv
// Bundle of SPI PHY word-level signals and SDRAM controller request signals.
// master = the bridge, slave = the PHY/controller environment.
interface spi_mem_bridge_if;

    logic        rx_valid;
    logic [15:0] rx_data;
    logic [15:0] tx_data;
    logic        tx_load;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_enable;
    logic [31:0] rd_addr;
    logic        rd_enable;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic        busy;
    logic        cmd_error;

    modport master (
        input  rx_valid, rx_data, rd_data, rd_ready, busy,
        output tx_data, tx_load, wr_addr, wr_data, wr_enable,
        output rd_addr, rd_enable, cmd_error
    );

    modport slave (
        output rx_valid, rx_data, rd_data, rd_ready, busy,
        input  tx_data, tx_load, wr_addr, wr_data, wr_enable,
        input  rd_addr, rd_enable, cmd_error
    );

endinterface

// File: rtl/spi_mem_timeout.sv
// Watchdog for inter-word gaps and read-data waits.
// expired fires on the TIMEOUT-th consecutive tick cycle after a load.
module spi_mem_timeout #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = tick && (cnt_q == W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (tick && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_mem_bridge.sv
// Decodes 16-bit SPI command words into single SDRAM read/write requests
// and a small status register file readable back over SPI.
module spi_mem_bridge
    import spi_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [15:0] ID_WORD = 16'hB51D
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_mem_bridge_if.master   bus
);

    state_e      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [15:0] addr_lo_q, addr_lo_d;
    logic [15:0] addr_hi_q, addr_hi_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        tx_load_q, tx_load_d;
    logic        cmd_error_q, cmd_error_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] last_rd_q, last_rd_d;

    logic        wr_en;
    logic        rd_en;
    logic [15:0] reg_rdata;
    logic        to_load;
    logic        to_tick;
    logic        to_expired;

    assign to_tick = state_q inside {ADDR_LO, ADDR_HI, WDATA, REG_ARG, RD_WAIT};
    assign to_load = (state_d != state_q);

    spi_mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (to_load),
        .tick    (to_tick),
        .expired (to_expired)
    );

    always_comb begin
        reg_rdata = 16'h0000;
        unique case (bus.rx_data[7:0])
            REG_ID:   reg_rdata = ID_WORD;
            REG_STAT: reg_rdata = {bus.busy, 7'b0, err_cnt_q};
            REG_LAST: reg_rdata = last_rd_q;
            default:  reg_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        addr_lo_d   = addr_lo_q;
        addr_hi_d   = addr_hi_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        cmd_error_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        last_rd_d   = last_rd_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == OP_RD) begin
                        is_wr_d = 1'b0;
                        state_d = ADDR_LO;
                    end else if (bus.rx_data == OP_WR) begin
                        is_wr_d = 1'b1;
                        state_d = ADDR_LO;
                    end else if (is_reg_op(bus.rx_data)) begin
                        tx_data_d = reg_rdata;
                        tx_load_d = 1'b1;
                        state_d   = REG_ARG;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            ADDR_LO: begin
                if (bus.rx_valid) begin
                    addr_lo_d = bus.rx_data;
                    state_d   = ADDR_HI;
                end else if (to_expired) begin
                    cmd_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            ADDR_HI: begin
                if (bus.rx_valid) begin
                    if (is_wr_q) begin
                        addr_hi_d = bus.rx_data;
                        state_d   = WDATA;
                    end else begin
                        rd_addr_d = {bus.rx_data, addr_lo_q};
                        state_d   = RD_ISSUE;
                    end
                end else if (to_expired) begin
                    cmd_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WDATA: begin
                if (bus.rx_valid) begin
                    wr_addr_d = {addr_hi_q, addr_lo_q};
                    wr_data_d = bus.rx_data;
                    state_d   = WR_ISSUE;
                end else if (to_expired) begin
                    cmd_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WR_ISSUE: begin
                cmd_error_d = bus.rx_valid;
                if (!bus.busy) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                cmd_error_d = bus.rx_valid;
                if (!bus.busy) begin
                    rd_en   = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                cmd_error_d = bus.rx_valid;
                if (bus.rd_ready) begin
                    tx_data_d = bus.rd_data;
                    last_rd_d = bus.rd_data;
                    tx_load_d = 1'b1;
                    state_d   = IDLE;
                end else if (to_expired) begin
                    tx_data_d   = DEAD_WORD;
                    tx_load_d   = 1'b1;
                    cmd_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            REG_ARG: begin
                if (bus.rx_valid) begin
                    state_d = IDLE;
                end else if (to_expired) begin
                    cmd_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Error counter saturates so a stuck host cannot wrap it back to zero.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cmd_error_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            addr_lo_q   <= '0;
            addr_hi_q   <= '0;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            cmd_error_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            err_cnt_q   <= '0;
            last_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            addr_lo_q   <= addr_lo_d;
            addr_hi_q   <= addr_hi_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            cmd_error_q <= cmd_error_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            err_cnt_q   <= err_cnt_d;
            last_rd_q   <= last_rd_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_load   = tx_load_q;
    assign bus.cmd_error = cmd_error_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_addr   = rd_addr_q;
    // Enables follow busy combinationally so the request lands on the
    // first cycle the controller is free.
    assign bus.wr_enable = wr_en;
    assign bus.rd_enable = rd_en;

endmodule

// File: doc/spi_mem_bridge.md
SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024; cycles allowed for an inter-word gap or an rd_ready wait.
REQ-002 SHALL have parameter ID_WORD, default 16'hB51D; value returned by register 0x00.
REQ-003 SHALL have port clk, input, 1; the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1; asynchronous active-low reset.
REQ-005 SHALL have port rx_valid, input, 1; one-cycle pulse, one 16-bit SPI word received.
REQ-006 SHALL have port rx_data, input, 16; received word, valid while rx_valid is high.
REQ-007 SHALL have port tx_data, output, 16; word the SPI PHY shifts out on the next exchange.
REQ-008 SHALL have port tx_load, output, 1; one-cycle pulse when tx_data is updated.
REQ-009 SHALL have port wr_addr, output, 32; SDRAM controller write address.
REQ-010 SHALL have port wr_data, output, 16; SDRAM controller write data.
REQ-011 SHALL have port wr_enable, output, 1; one-cycle write request.
REQ-012 SHALL have port rd_addr, output, 32; SDRAM controller read address.
REQ-013 SHALL have port rd_enable, output, 1; one-cycle read request.
REQ-014 SHALL have port rd_data, input, 16; read data from the controller.
REQ-015 SHALL have port rd_ready, input, 1; one-cycle pulse, rd_data valid.
REQ-016 SHALL have port busy, input, 1; controller cannot accept a request.
REQ-017 SHALL have port cmd_error, output, 1; one-cycle pulse on any protocol fault.

Function
REQ-018 SHALL implement FSM states IDLE, ADDR_LO, ADDR_HI, WDATA, WR_ISSUE, RD_ISSUE, RD_WAIT, REG_ARG.
REQ-019 SHALL handle word 16'hC000 in IDLE as a read command: IDLE->ADDR_LO->ADDR_HI->RD_ISSUE.
REQ-020 SHALL handle word 16'hC100 in IDLE as a write command: IDLE->ADDR_LO->ADDR_HI->WDATA->WR_ISSUE.
REQ-021 SHALL handle word 16'h80aa in IDLE as a register read of address aa: load tx_data with the register value next cycle, pulse tx_load, go to REG_ARG; the next rx_valid (dummy word) returns to IDLE.
REQ-022 SHALL map registers as: 0x00 = ID_WORD; 0x01 = {busy, 7'b0, error_count[7:0]}; 0x02 = last read data; all others = 16'h0000.
REQ-023 SHALL form the 32-bit address as {addr_hi_word, addr_lo_word}.
REQ-024 SHALL, in WR_ISSUE and RD_ISSUE, wait while busy=1, then assert wr_enable or rd_enable for exactly one cycle with address/data stable from that cycle until the next command, then go to IDLE (write) or RD_WAIT (read).
REQ-025 SHALL, on rd_ready in RD_WAIT, latch rd_data into tx_data and register 0x02, pulse tx_load in the same cycle, and go to IDLE.
REQ-026 SHALL, if rd_ready is absent for TIMEOUT cycles in RD_WAIT, load tx_data=16'hDEAD, pulse tx_load and cmd_error, and go to IDLE.
REQ-027 SHALL, if no rx_valid arrives for TIMEOUT cycles in ADDR_LO, ADDR_HI, WDATA or REG_ARG, pulse cmd_error and go to IDLE.
REQ-028 SHALL, on any unrecognised opcode in IDLE, pulse cmd_error and stay in IDLE.
REQ-029 SHALL, on rx_valid in WR_ISSUE, RD_ISSUE or RD_WAIT, drop the word, pulse cmd_error, and not change state.
REQ-030 SHALL increment error_count on every cmd_error pulse, saturating at 8'hFF.
REQ-031 SHALL never assert wr_enable and rd_enable in the same cycle.
REQ-032 SHALL ignore rd_ready outside RD_WAIT.

Reset
REQ-033 SHALL, while rst_n=0, force FSM=IDLE, tx_data=16'h0000, tx_load=0, wr_addr=0, wr_data=0, wr_enable=0, rd_addr=0, rd_enable=0, cmd_error=0, error_count=0, register 0x02=0, timeout counter=0.
REQ-034 SHALL, on reset mid-transaction, abandon the command with no enable pulse after rst_n rises.

Structure
REQ-035 SHALL take opcode constants (C000, C100, 80xx mask), register addresses, 16'hDEAD and the FSM state enum from a shared package spi_mem_pkg.
REQ-036 SHALL place the timeout counter in one sub-module, spi_mem_timeout (load, tick, expired).

Verification
REQ-037 SHALL test write: words C100,0000,0000,1234 with busy=0 -> one wr_enable pulse, wr_addr=0, wr_data=16'h1234.
REQ-038 SHALL test read: words C000,000A,0000 with rd_ready returning 16'h7777 three cycles later -> one rd_enable pulse with rd_addr=10, then tx_data=16'h7777 with tx_load.
REQ-039 SHALL test register read: words 8000,0000 -> tx_data=16'hB51D; then 8002,0000 -> tx_data=16'h7777.
REQ-040 SHALL test busy hold-off: busy=1 for 20 cycles during a write -> wr_enable is asserted exactly once, on the first cycle after busy falls.
REQ-041 SHALL test faults: opcode 16'h1234 -> cmd_error pulse and register 0x01 low byte=1; a read with no rd_ready -> tx_data=16'hDEAD after TIMEOUT cycles.
REQ-042 SHALL test reset abort: rst_n pulsed low after C100,0000 -> all outputs zero, no wr_enable, and the next C000 command is accepted normally.
